// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - request/response and memory-side signals of the unified memory arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;
    logic              if_stall;

    logic              dm_req;
    logic              dm_wr;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_done;
    logic              dm_stall;

    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // slave: the arbiter itself; master: pipeline stages plus memory model
    modport slave (
        input  if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall,
               mem_en, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall,
               mem_en, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fixed-priority arbiter sharing one fixed-latency memory between fetch and data ports
module mem_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_DM
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last_cycle;

    assign last_cycle = (cnt == '0) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_wr    <= 1'b0;
            bus.mem_addr  <= ADDR_W'(0);
            bus.mem_wdata <= DATA_W'(0);
        end else begin
            bus.mem_en <= 1'b0;
            case (state)
                IDLE: begin
                    // DM belongs to the older instruction, so it always wins
                    if (bus.dm_req) begin
                        state         <= BUSY_DM;
                        cnt           <= CNT_W'(MEM_LAT);
                        bus.mem_en    <= 1'b1;
                        bus.mem_wr    <= bus.dm_wr;
                        bus.mem_addr  <= bus.dm_addr;
                        bus.mem_wdata <= bus.dm_wdata;
                    end else if (bus.if_req) begin
                        state         <= BUSY_IF;
                        cnt           <= CNT_W'(MEM_LAT);
                        bus.mem_en    <= 1'b1;
                        bus.mem_wr    <= 1'b0;
                        bus.mem_addr  <= bus.if_addr;
                        bus.mem_wdata <= DATA_W'(0);
                    end
                end
                BUSY_IF, BUSY_DM: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // mem_wr stays latched for the whole access, so it doubles as the write flag
    always_comb begin
        bus.if_done  = (state == BUSY_IF) && last_cycle;
        bus.dm_done  = (state == BUSY_DM) && last_cycle;
        bus.if_rdata = bus.if_done ? bus.mem_rdata : '0;
        bus.dm_rdata = (bus.dm_done && !bus.mem_wr) ? bus.mem_rdata : '0;
        bus.if_stall = bus.if_req & ~bus.if_done;
        bus.dm_stall = bus.dm_req & ~bus.dm_done;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus0 ();
    mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();

    mem_arbiter #(.MEM_LAT(2), .ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus0)
    );

    mem_arbiter #(.MEM_LAT(1), .ADDR_W(16), .DATA_W(16)) dut_lat1 (
        .clk(clk),
        .rst(rst),
        .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // inputs change 1 time unit after the edge; checks follow 1 unit later
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        bus0.if_req = 0; bus0.if_addr = 0; bus0.dm_req = 0; bus0.dm_wr = 0;
        bus0.dm_addr = 0; bus0.dm_wdata = 0; bus0.mem_rdata = 0;
        bus1.if_req = 0; bus1.if_addr = 0; bus1.dm_req = 0; bus1.dm_wr = 0;
        bus1.dm_addr = 0; bus1.dm_wdata = 0; bus1.mem_rdata = 0;

        // reset held with both requests pending, DM granted on release
        cyc();
        bus0.if_req = 1; bus0.if_addr = 16'h0040;
        bus0.dm_req = 1; bus0.dm_addr = 16'h0100;
        cyc(); settle();
        chk("rst_mem_en", 32'(bus0.mem_en), 32'd0);
        chk("rst_if_done", 32'(bus0.if_done), 32'd0);
        chk("rst_dm_done", 32'(bus0.dm_done), 32'd0);
        chk("rst_if_stall", 32'(bus0.if_stall), 32'd1);
        chk("rst_dm_stall", 32'(bus0.dm_stall), 32'd1);
        chk("rst_mem_addr", 32'(bus0.mem_addr), 32'h0);
        cyc(); rst = 0; settle();
        chk("rel_c0_mem_en", 32'(bus0.mem_en), 32'd0);
        cyc(); settle();
        chk("rel_c1_mem_en", 32'(bus0.mem_en), 32'd1);
        chk("rel_c1_mem_addr", 32'(bus0.mem_addr), 32'h0100);
        cyc(); settle();
        cyc(); bus0.mem_rdata = 16'h5555; settle();
        chk("rel_c3_dm_done", 32'(bus0.dm_done), 32'd1);
        chk("rel_c3_dm_rdata", 32'(bus0.dm_rdata), 32'h5555);
        chk("rel_c3_if_done", 32'(bus0.if_done), 32'd0);
        cyc(); bus0.if_req = 0; bus0.dm_req = 0; bus0.mem_rdata = 0; settle();
        cyc(); settle();
        chk("idle_mem_en", 32'(bus0.mem_en), 32'd0);

        // single fetch
        cyc(); bus0.if_req = 1; bus0.if_addr = 16'h0040; settle();
        chk("if_c0_stall", 32'(bus0.if_stall), 32'd1);
        chk("if_c0_mem_en", 32'(bus0.mem_en), 32'd0);
        cyc(); settle();
        chk("if_c1_mem_en", 32'(bus0.mem_en), 32'd1);
        chk("if_c1_mem_addr", 32'(bus0.mem_addr), 32'h0040);
        chk("if_c1_mem_wr", 32'(bus0.mem_wr), 32'd0);
        chk("if_c1_stall", 32'(bus0.if_stall), 32'd1);
        cyc(); bus0.mem_rdata = 16'hDEAD; settle();
        chk("if_c2_mem_en", 32'(bus0.mem_en), 32'd0);
        chk("if_c2_done", 32'(bus0.if_done), 32'd0);
        chk("if_c2_rdata", 32'(bus0.if_rdata), 32'h0);
        chk("if_c2_stall", 32'(bus0.if_stall), 32'd1);
        cyc(); bus0.mem_rdata = 16'h1234; settle();
        chk("if_c3_done", 32'(bus0.if_done), 32'd1);
        chk("if_c3_rdata", 32'(bus0.if_rdata), 32'h1234);
        chk("if_c3_stall", 32'(bus0.if_stall), 32'd0);
        chk("if_c3_dm_done", 32'(bus0.dm_done), 32'd0);
        chk("if_c3_dm_rdata", 32'(bus0.dm_rdata), 32'h0);
        cyc(); bus0.if_req = 0; bus0.mem_rdata = 0; settle();
        chk("if_c4_done", 32'(bus0.if_done), 32'd0);

        // simultaneous requests: DM first, IF after one idle cycle
        cyc(); bus0.if_req = 1; bus0.if_addr = 16'h0044;
        bus0.dm_req = 1; bus0.dm_addr = 16'h0200; settle();
        cyc(); settle();
        chk("both_c1_mem_en", 32'(bus0.mem_en), 32'd1);
        chk("both_c1_mem_addr", 32'(bus0.mem_addr), 32'h0200);
        cyc(); settle();
        chk("both_c2_if_stall", 32'(bus0.if_stall), 32'd1);
        cyc(); bus0.mem_rdata = 16'hAAAA; settle();
        chk("both_c3_dm_done", 32'(bus0.dm_done), 32'd1);
        chk("both_c3_dm_rdata", 32'(bus0.dm_rdata), 32'hAAAA);
        chk("both_c3_if_done", 32'(bus0.if_done), 32'd0);
        chk("both_c3_if_rdata", 32'(bus0.if_rdata), 32'h0);
        chk("both_c3_if_stall", 32'(bus0.if_stall), 32'd1);
        cyc(); bus0.dm_req = 0; bus0.mem_rdata = 0; settle();
        chk("both_c4_mem_en", 32'(bus0.mem_en), 32'd0);
        chk("both_c4_if_stall", 32'(bus0.if_stall), 32'd1);
        cyc(); settle();
        chk("both_c5_mem_en", 32'(bus0.mem_en), 32'd1);
        chk("both_c5_mem_addr", 32'(bus0.mem_addr), 32'h0044);
        cyc(); settle();
        chk("both_c6_if_stall", 32'(bus0.if_stall), 32'd1);
        chk("both_c6_if_done", 32'(bus0.if_done), 32'd0);
        cyc(); bus0.mem_rdata = 16'h7777; settle();
        chk("both_c7_if_done", 32'(bus0.if_done), 32'd1);
        chk("both_c7_if_rdata", 32'(bus0.if_rdata), 32'h7777);
        cyc(); bus0.if_req = 0; bus0.mem_rdata = 0; settle();

        // data write, wdata change during BUSY is ignored
        cyc(); bus0.dm_req = 1; bus0.dm_wr = 1; bus0.dm_addr = 16'h00A0;
        bus0.dm_wdata = 16'hBEEF; settle();
        cyc(); bus0.dm_wdata = 16'h1111; settle();
        chk("wr_c1_mem_en", 32'(bus0.mem_en), 32'd1);
        chk("wr_c1_mem_wr", 32'(bus0.mem_wr), 32'd1);
        chk("wr_c1_mem_addr", 32'(bus0.mem_addr), 32'h00A0);
        chk("wr_c1_mem_wdata", 32'(bus0.mem_wdata), 32'hBEEF);
        cyc(); settle();
        chk("wr_c2_mem_wdata", 32'(bus0.mem_wdata), 32'hBEEF);
        cyc(); bus0.mem_rdata = 16'h9999; settle();
        chk("wr_c3_dm_done", 32'(bus0.dm_done), 32'd1);
        chk("wr_c3_dm_rdata", 32'(bus0.dm_rdata), 32'h0);
        cyc(); bus0.dm_req = 0; bus0.dm_wr = 0; bus0.mem_rdata = 0; settle();

        // reset mid-access abandons it; next fetch proceeds normally
        cyc(); bus0.dm_req = 1; bus0.dm_addr = 16'h0300; settle();
        cyc(); settle();
        chk("abt_c1_mem_en", 32'(bus0.mem_en), 32'd1);
        cyc(); rst = 1; settle();
        cyc(); rst = 0; bus0.dm_req = 0; bus0.if_req = 1; bus0.if_addr = 16'h0050;
        bus0.mem_rdata = 16'h4444; settle();
        chk("abt_c3_dm_done", 32'(bus0.dm_done), 32'd0);
        chk("abt_c3_dm_rdata", 32'(bus0.dm_rdata), 32'h0);
        chk("abt_c3_mem_en", 32'(bus0.mem_en), 32'd0);
        cyc(); bus0.mem_rdata = 0; settle();
        chk("abt_c4_mem_en", 32'(bus0.mem_en), 32'd1);
        chk("abt_c4_mem_addr", 32'(bus0.mem_addr), 32'h0050);
        cyc(); settle();
        cyc(); bus0.mem_rdata = 16'h3C3C; settle();
        chk("abt_c6_if_done", 32'(bus0.if_done), 32'd1);
        chk("abt_c6_if_rdata", 32'(bus0.if_rdata), 32'h3C3C);
        cyc(); bus0.if_req = 0; bus0.mem_rdata = 0; settle();

        // MEM_LAT=1 instance: address latched at issue
        cyc(); bus1.dm_req = 1; bus1.dm_addr = 16'h0010; settle();
        cyc(); bus1.dm_addr = 16'h0020; settle();
        chk("l1_c1_mem_en", 32'(bus1.mem_en), 32'd1);
        chk("l1_c1_mem_addr", 32'(bus1.mem_addr), 32'h0010);
        chk("l1_c1_dm_done", 32'(bus1.dm_done), 32'd0);
        cyc(); bus1.mem_rdata = 16'h6666; settle();
        chk("l1_c2_dm_done", 32'(bus1.dm_done), 32'd1);
        chk("l1_c2_dm_rdata", 32'(bus1.dm_rdata), 32'h6666);
        chk("l1_c2_mem_addr", 32'(bus1.mem_addr), 32'h0010);
        chk("l1_c2_mem_en", 32'(bus1.mem_en), 32'd0);
        cyc(); bus1.dm_req = 0; bus1.mem_rdata = 0; settle();
        chk("l1_c3_dm_done", 32'(bus1.dm_done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
